// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths and ALU function codes for the ALU arbiter slice
package alu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int FUNC_WIDTH = 4;

    typedef enum logic [FUNC_WIDTH-1:0] {
        ALU_ZERO = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SLL  = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_func_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, purely combinational
//
// Ports:
//   i_eligible  [1:0]  requesters that may be granted this cycle
//   i_ptr              requester holding priority when both are eligible
//   o_grant     [1:0]  one-hot grant (all zero when nobody is eligible)
//   o_next_ptr         priority for the next cycle: the non-granted side after
//                      a grant, unchanged when there was no grant
module rr_arb2 (
    input  logic [1:0] i_eligible,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_next_ptr
);

    always_comb begin
        o_grant    = 2'b00;
        o_next_ptr = i_ptr;
        case (i_eligible)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
        if (o_grant[0]) begin
            o_next_ptr = 1'b1;
        end else if (o_grant[1]) begin
            o_next_ptr = 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one registered ALU between two requesters with per-requester result buffers
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req{0,1}_valid/ready     operation handshake (ready is combinational grant)
//   req{0,1}_func/op1/op2    operation fields
//   rsp{0,1}_valid/ready     result handshake from a one-entry buffer
//   rsp{0,1}_data            buffered result, stable while valid && !ready
//   alu_func/op1/op2         issue to the external ALU (zero when idle)
//   alu_result               ALU output, registered, valid the cycle after issue
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int FUNC_WIDTH = alu_pkg::FUNC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [FUNC_WIDTH-1:0] req0_func,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_data,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [FUNC_WIDTH-1:0] req1_func,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_data,

    output logic [FUNC_WIDTH-1:0] alu_func,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    input  logic [DATA_WIDTH-1:0] alu_result
);

    logic                  r_rr_ptr;
    logic                  r_inflight_valid;
    logic                  r_inflight_owner;
    logic [1:0]            r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data0;
    logic [DATA_WIDTH-1:0] r_rsp_data1;

    logic [1:0]            w_eligible;
    logic [1:0]            w_grant;
    logic                  w_next_ptr;
    logic [1:0]            w_capture;
    logic [1:0]            w_drain;

    // A requester may not issue while its own op is in flight, and it may
    // only issue if its buffer is empty or being drained this cycle, so a
    // returning result never overwrites an unconsumed one. Gating with rst
    // keeps both readies low for the whole reset window.
    assign w_eligible[0] = !rst && req0_valid
                           && !(r_inflight_valid && !r_inflight_owner)
                           && (!r_rsp_valid[0] || rsp0_ready);
    assign w_eligible[1] = !rst && req1_valid
                           && !(r_inflight_valid && r_inflight_owner)
                           && (!r_rsp_valid[1] || rsp1_ready);

    rr_arb2 u_rr_arb2 (
        .i_eligible (w_eligible),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_next_ptr (w_next_ptr)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    // Issue mux: the ALU registers these at the edge that ends the grant cycle.
    always_comb begin
        alu_func = FUNC_WIDTH'(ALU_ZERO);
        alu_op1  = '0;
        alu_op2  = '0;
        if (w_grant[0]) begin
            alu_func = req0_func;
            alu_op1  = req0_op1;
            alu_op2  = req0_op2;
        end else if (w_grant[1]) begin
            alu_func = req1_func;
            alu_op1  = req1_op1;
            alu_op2  = req1_op2;
        end
    end

    assign w_capture[0] = r_inflight_valid && !r_inflight_owner;
    assign w_capture[1] = r_inflight_valid &&  r_inflight_owner;
    assign w_drain[0]   = r_rsp_valid[0] && rsp0_ready;
    assign w_drain[1]   = r_rsp_valid[1] && rsp1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr         <= 1'b0;
            r_inflight_valid <= 1'b0;
            r_inflight_owner <= 1'b0;
            r_rsp_valid      <= 2'b00;
            r_rsp_data0      <= '0;
            r_rsp_data1      <= '0;
        end else begin
            r_rr_ptr         <= w_next_ptr;
            r_inflight_valid <= |w_grant;
            if (|w_grant) begin
                r_inflight_owner <= w_grant[1];
            end

            // Capture takes precedence over a drain in the same cycle so the
            // fresh result is kept rather than lost.
            if (w_capture[0]) begin
                r_rsp_data0    <= alu_result;
                r_rsp_valid[0] <= 1'b1;
            end else if (w_drain[0]) begin
                r_rsp_valid[0] <= 1'b0;
            end

            if (w_capture[1]) begin
                r_rsp_data1    <= alu_result;
                r_rsp_valid[1] <= 1'b1;
            end else if (w_drain[1]) begin
                r_rsp_valid[1] <= 1'b0;
            end
        end
    end

    assign rsp0_valid = r_rsp_valid[0];
    assign rsp1_valid = r_rsp_valid[1];
    assign rsp0_data  = r_rsp_data0;
    assign rsp1_data  = r_rsp_data1;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural one-cycle ALU
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [FW-1:0] req0_func;
    logic [DW-1:0] req0_op1, req0_op2, rsp0_data;
    logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [FW-1:0] req1_func;
    logic [DW-1:0] req1_op1, req1_op2, rsp1_data;
    logic [FW-1:0] alu_func;
    logic [DW-1:0] alu_op1, alu_op2;
    logic [DW-1:0] alu_result = '0;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_func(alu_func), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result)
    );

    function automatic logic [DW-1:0] alu_ref(input logic [FW-1:0] f,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (f)
            4'd0:    return '0;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a << b[4:0];
            4'd4:    return {31'b0, $signed(a) < $signed(b)};
            4'd5:    return a ^ b;
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd8:    return a >> b[4:0];
            4'd9:    return $signed(a) >>> b[4:0];
            4'd10:   return {31'b0, a < b};
            default: return 32'hBAD0_0000 | {28'b0, f};
        endcase
    endfunction

    // Behavioural ALU: result registered one cycle after issue.
    always @(posedge clk) alu_result <= alu_ref(alu_func, alu_op1, alu_op2);

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        if (req0_valid && req0_ready) begin
            q0.push_back(alu_ref(req0_func, req0_op1, req0_op2));
            check("issue0_func", 32'(alu_func), 32'(req0_func));
            check("issue0_op1", alu_op1, req0_op1);
        end
        if (req1_valid && req1_ready) begin
            q1.push_back(alu_ref(req1_func, req1_op1, req1_op2));
            check("issue1_func", 32'(alu_func), 32'(req1_func));
            check("issue1_op2", alu_op2, req1_op2);
        end
        if (rsp0_valid && rsp0_ready) begin
            if (q0.size() == 0) check("rsp0_unexpected", 32'(1), 32'(0));
            else check("rsp0_data_sb", rsp0_data, q0.pop_front());
        end
        if (rsp1_valid && rsp1_ready) begin
            if (q1.size() == 0) check("rsp1_unexpected", 32'(1), 32'(0));
            else check("rsp1_data_sb", rsp1_data, q1.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [FW-1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req0_valid = v; req0_func = f; req0_op1 = a; req0_op2 = b;
    endtask

    task automatic set1(input logic v, input logic [FW-1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req1_valid = v; req1_func = f; req1_op1 = a; req1_op2 = b;
    endtask

    task automatic do_reset;
        tick; rst = 1'b1;
        tick; rst = 1'b0;
        q0.delete(); q1.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic g0, g1, prev_g0;
        int   n_grants;
        rst = 1'b1;
        set0(1'b0, '0, '0, '0);
        set1(1'b0, '0, '0, '0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Reset state
        repeat (2) tick;
        @(negedge clk);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'(0));
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'(0));
        check("rst_rsp0_data", rsp0_data, 32'(0));
        check("rst_rsp1_data", rsp1_data, 32'(0));
        tick; set0(1'b1, 4'd1, 32'd1, 32'd2); set1(1'b1, 4'd2, 32'd3, 32'd4);
        @(negedge clk);
        check("rst_req0_ready", 32'(req0_ready), 32'(0));
        check("rst_req1_ready", 32'(req1_ready), 32'(0));
        check("rst_alu_func", 32'(alu_func), 32'(0));
        check("rst_alu_op1", alu_op1, 32'(0));
        tick; req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;

        // Single op: ADD 5,7
        tick; set0(1'b1, 4'd1, 32'd5, 32'd7);
        @(negedge clk);
        check("single_ready", 32'(req0_ready), 32'(1));
        check("single_alu_op2", alu_op2, 32'd7);
        tick; req0_valid = 1'b0;
        @(negedge clk); check("single_t1_valid", 32'(rsp0_valid), 32'(0));
        tick; rsp0_ready = 1'b1;
        @(negedge clk);
        check("single_t2_valid", 32'(rsp0_valid), 32'(1));
        check("single_t2_data", rsp0_data, 32'd12);
        tick;
        @(negedge clk); check("single_t3_cleared", 32'(rsp0_valid), 32'(0));

        // Contention after reset: req0 wins first (pointer reset to 0)
        do_reset;
        tick; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        set0(1'b1, 4'd2, 32'd10, 32'd3);
        set1(1'b1, 4'd5, 32'h0000_00F0, 32'h0000_00FF);
        @(negedge clk);
        check("cont_t0_r0", 32'(req0_ready), 32'(1));
        check("cont_t0_r1", 32'(req1_ready), 32'(0));
        tick; req0_valid = 1'b0;
        @(negedge clk); check("cont_t1_r1", 32'(req1_ready), 32'(1));
        tick; req1_valid = 1'b0;
        @(negedge clk);
        check("cont_t2_rsp0_valid", 32'(rsp0_valid), 32'(1));
        check("cont_t2_rsp0_data", rsp0_data, 32'd7);
        tick; set0(1'b1, 4'd1, 32'd1, 32'd1); set1(1'b1, 4'd1, 32'd2, 32'd2);
        @(negedge clk);
        check("cont_t3_rsp1_valid", 32'(rsp1_valid), 32'(1));
        check("cont_t3_rsp1_data", rsp1_data, 32'h0000_000F);
        check("cont_t3_r0", 32'(req0_ready), 32'(1));
        check("cont_t3_r1", 32'(req1_ready), 32'(0));
        tick; req0_valid = 1'b0;
        @(negedge clk); check("cont_t4_r1", 32'(req1_ready), 32'(1));
        tick; req1_valid = 1'b0;
        repeat (3) tick;

        // Backpressure: full buffer blocks the next op until drained
        rsp0_ready = 1'b0; set0(1'b1, 4'd1, 32'd5, 32'd7);
        @(negedge clk); check("bp_first_ready", 32'(req0_ready), 32'(1));
        tick; req0_valid = 1'b0;
        tick; set0(1'b1, 4'd7, 32'h0000_00FF, 32'h0000_000F);
        @(negedge clk);
        check("bp_held_valid", 32'(rsp0_valid), 32'(1));
        check("bp_held_data", rsp0_data, 32'd12);
        check("bp_blocked_a", 32'(req0_ready), 32'(0));
        tick;
        @(negedge clk);
        check("bp_blocked_b", 32'(req0_ready), 32'(0));
        check("bp_stable_data", rsp0_data, 32'd12);
        tick; rsp0_ready = 1'b1;
        @(negedge clk); check("bp_granted", 32'(req0_ready), 32'(1));
        tick; rsp0_ready = 1'b0; req0_valid = 1'b0;
        @(negedge clk); check("bp_gap_valid", 32'(rsp0_valid), 32'(0));
        tick;
        @(negedge clk);
        check("bp_new_valid", 32'(rsp0_valid), 32'(1));
        check("bp_new_data", rsp0_data, 32'h0000_000F);
        tick; rsp0_ready = 1'b1;
        tick;

        // Back-to-back ops from one requester with the consumer always ready
        tick; set0(1'b1, 4'd3, 32'd1, 32'd4);
        @(negedge clk); check("b2b_first_ready", 32'(req0_ready), 32'(1));
        tick; set0(1'b1, 4'd4, 32'hFFFF_FFFF, 32'd0);
        @(negedge clk); check("b2b_inflight_block", 32'(req0_ready), 32'(0));
        tick;
        @(negedge clk);
        check("b2b_d1_valid", 32'(rsp0_valid), 32'(1));
        check("b2b_d1_data", rsp0_data, 32'd16);
        check("b2b_second_ready", 32'(req0_ready), 32'(1));
        tick; req0_valid = 1'b0;
        tick;
        @(negedge clk);
        check("b2b_d2_valid", 32'(rsp0_valid), 32'(1));
        check("b2b_d2_data", rsp0_data, 32'd1);
        tick;

        // Reset while an op is in flight
        tick; set1(1'b1, 4'd9, 32'h8000_0000, 32'd4); rsp1_ready = 1'b1;
        @(negedge clk); check("rmid_grant", 32'(req1_ready), 32'(1));
        tick; req1_valid = 1'b0; rst = 1'b1; q1.delete();
        set0(1'b1, 4'd1, 32'd3, 32'd3);
        @(negedge clk); check("rmid_ready_in_rst", 32'(req0_ready), 32'(0));
        tick; rst = 1'b0; req0_valid = 1'b0;
        @(negedge clk); check("rmid_rsp1_dropped", 32'(rsp1_valid), 32'(0));
        for (int k = 0; k < 3; k++) begin
            tick;
            @(negedge clk); check("rmid_no_stale", 32'(rsp1_valid), 32'(0));
        end
        tick; set0(1'b1, 4'd1, 32'd8, 32'd9); set1(1'b1, 4'd6, 32'h0F00, 32'h00F0);
        @(negedge clk);
        check("rmid_ptr_r0", 32'(req0_ready), 32'(1));
        check("rmid_ptr_r1", 32'(req1_ready), 32'(0));
        tick; req0_valid = 1'b0;
        tick; req1_valid = 1'b0;
        repeat (3) tick;

        // Throughput: both always valid, random ops including codes 11-15
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        set0(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
        set1(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
        n_grants = 0;
        prev_g0  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            g0 = req0_ready;
            g1 = req1_ready;
            check("tp_one_grant", 32'(g0) + 32'(g1), 32'(1));
            if (i > 0) check("tp_alternate", 32'(g0), 32'(!prev_g0));
            n_grants += int'(g0) + int'(g1);
            prev_g0 = g0;
            tick;
            if (g0) set0(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
            if (g1) set1(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
        end
        check("tp_utilization", 32'(n_grants), 32'(20));
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick;
        check("sb_q0_empty", 32'(q0.size()), 32'(0));
        check("sb_q1_empty", 32'(q1.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
